// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: size/state encodings and lane helpers shared by the data memory controller
package data_mem_ctrl_pkg;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_R = 2'd3;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
    return size == SIZE_B ? 4'b0001 << lane : size == SIZE_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic uns);
    logic [15:0] sh;
    sh = 16'(word >> {lane, 3'b000});
    return size == SIZE_B ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == SIZE_H ? {{16{~uns & sh[15]}}, sh[15:0]} : word;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: valid/ready request and response channels of the data memory controller
interface data_mem_ctrl_if #(parameter int ADDR_W = 32) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  modport master (output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/data_mem_bank.sv
// data_mem_bank: four byte-wide RAM lanes with per-lane write enable and a registered read
module data_mem_bank #(
  parameter int DEPTH = 1024,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (be[l]) mem[idx] <= wdata[8*l +: 8];
      if (en) q <= mem[idx];
    end
    assign rdata[8*l +: 8] = q;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: serialised byte/half/word load-store controller in front of on-chip RAM
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic clk,
  input logic rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic we, uns, err;
  logic [1:0] size, lane;
  logic [31:0] wdata, bank_rdata;
  logic [3:0] be;
  assign lane = addr[1:0];
  assign err = size == SIZE_R || (size == SIZE_H && addr[0]) || (size == SIZE_W && lane != 2'd0) ||
               (addr >> (IW + 2)) != '0;
  assign be = (state == S_ACCESS && we && !err) ? lane_en(size, lane) : 4'b0000;
  data_mem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk(clk),
    .en(state == S_ACCESS),
    .be(be),
    .idx(addr[IW+1:2]),
    .wdata(wdata << {lane, 3'b000}),
    .rdata(bank_rdata)
  );
  // RESP spends its first cycle aligning the bank's registered read, then raises rsp_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      addr <= '0;
      we <= 1'b0;
      uns <= 1'b0;
      size <= SIZE_B;
      wdata <= ZeroWord;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= ZeroWord;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (bus.req_valid && bus.req_ready) begin
            addr <= bus.req_addr;
            we <= bus.req_we;
            uns <= bus.req_unsigned;
            size <= bus.req_size;
            wdata <= bus.req_wdata;
            cnt <= WLOAD;
            bus.req_ready <= 1'b0;
            state <= WAIT_CYCLES > 0 ? S_WAIT : S_ACCESS;
          end else bus.req_ready <= 1'b1;
        S_WAIT:
          if (cnt == 4'd0) state <= S_ACCESS;
          else cnt <= cnt - 4'd1;
        S_ACCESS: state <= S_RESP;
        S_RESP:
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= err;
            bus.rsp_rdata <= (err || we) ? ZeroWord : load_align(bank_rdata, size, lane, uns);
          end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random load/store checks of two controllers (0 and 3 wait states)
module tb_data_mem_ctrl;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] v = '0, w = '0, u = '0, rr = '0;
  logic [1:0][31:0] ad = '0, wd = '0;
  logic [1:0][1:0] sz = '0;
  logic [1:0] rdy, rv, er;
  logic [1:0][31:0] rdv;
  logic [7:0] mdl [2][4*DEPTH];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gd
    data_mem_ctrl_if #(.ADDR_W(32)) bus ();
    assign bus.req_valid = v[g];
    assign bus.req_we = w[g];
    assign bus.req_addr = ad[g];
    assign bus.req_size = sz[g];
    assign bus.req_unsigned = u[g];
    assign bus.req_wdata = wd[g];
    assign bus.rsp_ready = rr[g];
    assign rdy[g] = bus.req_ready;
    assign rv[g] = bus.rsp_valid;
    assign rdv[g] = bus.rsp_rdata;
    assign er[g] = bus.rsp_err;
    data_mem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(g * 3)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic xact(input int d, input logic wr, input logic [31:0] a, input logic [1:0] s,
                      input logic un, input logic [31:0] data, input int stall,
                      output logic [31:0] rd, output logic e, output int lat);
    int n = 0;
    while (!rdy[d] && n < 100) begin @(posedge clk); #1; n++; end
    check("req_ready_wait", 32'(n < 100), 1);
    v[d] = 1'b1; w[d] = wr; ad[d] = a; sz[d] = s; u[d] = un; wd[d] = data;
    @(posedge clk); #1;
    v[d] = 1'b0;
    lat = 0;
    while (!rv[d] && lat < 100) begin @(posedge clk); #1; lat++; end
    rd = rdv[d];
    e = er[d];
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rv[d]), 1);
      check("hold_rdata", rdv[d], rd);
      check("hold_ready_low", 32'(rdy[d]), 0);
    end
    rr[d] = 1'b1;
    @(posedge clk); #1;
    rr[d] = 1'b0;
    check("valid_drop", 32'(rv[d]), 0);
    check("ready_back", 32'(rdy[d]), 1);
  endtask
  // reference: little-endian byte memory with natural-alignment and range rules
  task automatic run(input int d, input logic wr, input logic [31:0] a, input logic [1:0] s,
                     input logic un, input logic [31:0] data, input int stall, output logic [31:0] rd);
    logic e, ee;
    logic [31:0] ed;
    int lat, nb;
    nb = 1 << s;
    ee = s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || a >= 32'(4 * DEPTH);
    ed = '0;
    if (!wr && !ee) begin
      for (int i = 0; i < nb; i++) ed |= 32'(mdl[d][int'(a) + i]) << (8 * i);
      if (!un && nb < 4 && ed[8*nb-1]) ed |= 32'hFFFF_FFFF << (8 * nb);
    end
    xact(d, wr, a, s, un, data, stall, rd, e, lat);
    check("latency", 32'(lat), 32'(d * 3 + 2));
    check("rsp_err", 32'(e), 32'(ee));
    check("rsp_rdata", rd, ed);
    if (wr && !ee) for (int i = 0; i < nb; i++) mdl[d][int'(a) + i] = data[8*i +: 8];
  endtask
  initial begin
    logic [31:0] r, a;
    logic [1:0] s;
    int d;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(rdy[k]), 0);
      check("rst_valid", 32'(rv[k]), 0);
      check("rst_rdata", rdv[k], 0);
      check("rst_err", 32'(er[k]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(rdy), 32'b11);
    run(0, 1, 32'h0, 2'd2, 0, 32'h0BAD_F00D, 0, r);
    run(0, 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF, 0, r);
    run(0, 0, 32'h10, 2'd2, 0, 0, 0, r);
    check("t1_word", r, 32'hDEAD_BEEF);
    run(0, 1, 32'h13, 2'd0, 0, 32'h80, 0, r);
    run(0, 0, 32'h13, 2'd0, 0, 0, 0, r);
    check("t2_byte_signed", r, 32'hFFFF_FF80);
    run(0, 0, 32'h13, 2'd0, 1, 0, 0, r);
    check("t2_byte_unsigned", r, 32'h0000_0080);
    run(0, 0, 32'h10, 2'd2, 0, 0, 0, r);
    check("t2_word", r, 32'h80AD_BEEF);
    run(0, 0, 32'h11, 2'd1, 0, 0, 0, r);
    run(0, 1, 32'(4 * DEPTH), 2'd2, 0, 32'hFFFF_FFFF, 0, r);
    run(0, 0, 32'h0, 2'd2, 0, 0, 0, r);
    check("t3_unchanged", r, 32'h0BAD_F00D);
    run(1, 1, 32'h40, 2'd2, 0, 32'h5555_6666, 5, r);
    run(1, 0, 32'h40, 2'd1, 1, 0, 5, r);
    check("t4_half", r, 32'h0000_6666);
    run(1, 1, 32'h20, 2'd2, 0, 32'h1111_1111, 0, r);
    v[1] = 1'b1; w[1] = 1'b1; ad[1] = 32'h20; sz[1] = 2'd2; wd[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    v[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(rdy[1]), 0);
    check("t5_rst_valid", 32'(rv[1]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(1, 0, 32'h20, 2'd2, 0, 0, 0, r);
    check("t5_no_write", r, 32'h1111_1111);
    run(0, 1, 32'h20, 2'd2, 0, 32'hAAAA_AAAA, 0, r);
    run(0, 1, 32'h22, 2'd1, 0, 32'h0000_1234, 0, r);
    run(0, 0, 32'h20, 2'd2, 0, 0, 0, r);
    check("t6_word", r, 32'h1234_AAAA);
    run(0, 0, 32'h22, 2'd1, 0, 0, 0, r);
    check("t6_half", r, 32'h0000_1234);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) run(k, 1, 32'(4 * i), 2'd2, 0, $urandom, 0, r);
    for (int i = 0; i < 200; i++) begin
      d = int'($urandom_range(1));
      a = $urandom_range(9) == 0 ? ($urandom_range(1) == 0 ? 32'(4 * DEPTH) + $urandom_range(15) : $urandom)
                                 : 32'($urandom_range(63));
      s = $urandom_range(7) == 0 ? 2'd3 : 2'($urandom_range(2));
      run(d, 1'($urandom), a, s, 1'($urandom), $urandom, int'($urandom_range(2)), r);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
